// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device transmitter.
//
// Sends one command byte to a PS/2 device (mouse) using the inhibit /
// request-to-send / device-clocked bits / ack handshake. The clock and data
// pins are open-drain, so each line has a value output and a direction output
// (dir=1 drives the value, dir=0 releases the line to its pull-up). Runs on
// cpuclk beside the PS/2 receive path.
//
// Optional feature macro: PS2_TX_RETRY_EN
//   defined   : a failed attempt restarts at INHIBIT with the latched byte,
//               up to 2 retries; tx_err only after the 3rd failure and
//               tx_busy stays high across retries.
//   undefined : the first failure raises tx_err.
//
// Parameters:
//   INHIBIT_CYCLES  clocks the PS/2 clock is held low before RTS
//   TIMEOUT_CYCLES  max clocks between device clock falls / final release
//
// Ports:
//   clk, reset                  cpuclk; synchronous active-high reset
//   tx_data[7:0], tx_start      byte and 1-cycle request (ignored while busy)
//   tx_busy, tx_done, tx_err    status; done/err are 1-cycle pulses
//   ps2_clk_in, ps2_data_in     raw asynchronous pin inputs
//   ps2_clk_out, ps2_clk_dir    clock pin value (always 0) and drive enable
//   ps2_data_out, ps2_data_dir  data pin value and drive enable
//   state_out[3:0]              current FSM state for LEDs / spy logic
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_out,
  output logic       ps2_clk_dir,
  output logic       ps2_data_out,
  output logic       ps2_data_dir,
  output logic [3:0] state_out
);

  localparam int MAX_CNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1) + 1;
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_INHIBIT  = 4'd1,
    S_RTS      = 4'd2,
    S_BITS     = 4'd3,
    S_ACK      = 4'd4,
    S_WAIT_REL = 4'd5,
    S_DONE     = 4'd6,
    S_ERR      = 4'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [9:0]       shift_q, shift_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             clk_dir_q, clk_dir_d;
  logic             data_dir_q, data_dir_d;
  logic             data_out_q, data_out_d;
  logic             clk_s1_q, clk_s2_q, clk_s3_q;
  logic             data_s1_q, data_s2_q;
  logic             fall;
  logic             fail;
`ifdef PS2_TX_RETRY_EN
  logic [7:0]       byte_q, byte_d;
  logic [1:0]       retry_q, retry_d;
`endif

  assign fall = clk_s3_q & ~clk_s2_q;

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef PS2_TX_RETRY_EN
    byte_q  <= byte_d;
`endif
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      clk_dir_q  <= 1'b0;
      data_dir_q <= 1'b0;
      data_out_q <= 1'b1;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_s3_q   <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
`ifdef PS2_TX_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      clk_dir_q  <= clk_dir_d;
      data_dir_q <= data_dir_d;
      data_out_q <= data_out_d;
      // pin synchronizers; clk_s3 is the extra flop for fall detection
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_s3_q   <= clk_s2_q;
      data_s1_q  <= ps2_data_in;
      data_s2_q  <= data_s1_q;
`ifdef PS2_TX_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_dir_d = data_dir_q;
    data_out_d = data_out_q;
    fail       = 1'b0;
`ifdef PS2_TX_RETRY_EN
    byte_d     = byte_q;
    retry_d    = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        // device->host clock activity is ignored here
        if (tx_start) begin
          shift_d = {1'b1, ~^tx_data, tx_data};
          cnt_d   = '0;
          state_d = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          byte_d  = tx_data;
          retry_d = '0;
`endif
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = S_RTS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RTS, S_BITS: begin
        if (fall) begin
          cnt_d = '0;
          if (state_q == S_BITS && bit_cnt_q == 4'd9) begin
            // fall #10 is the stop bit: release data, it reads back as 1
            state_d = S_ACK;
          end else begin
            data_out_d = shift_q[0];
            shift_d    = {1'b0, shift_q[9:1]};
            bit_cnt_d  = bit_cnt_q + 4'd1;
            state_d    = S_BITS;
          end
        end else if (cnt_q >= TO_LIMIT) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACK: begin
        if (fall) begin
          cnt_d = '0;
          if (!data_s2_q) state_d = S_WAIT_REL;
          else            fail    = 1'b1;
        end else if (cnt_q >= TO_LIMIT) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_REL: begin
        if (clk_s2_q && data_s2_q)  state_d = S_DONE;
        else if (cnt_q >= TO_LIMIT) fail    = 1'b1;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
`ifdef PS2_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d = retry_q + 2'd1;
        shift_d = {1'b1, ~^byte_q, byte_q};
        cnt_d   = '0;
        state_d = S_INHIBIT;
      end else begin
        state_d = S_ERR;
      end
`else
      state_d = S_ERR;
`endif
    end

    // Pin and status outputs are registered from the next state so the
    // open-drain enables never glitch on state decode.
    clk_dir_d = (state_d == S_INHIBIT);
    busy_d    = state_d inside {S_INHIBIT, S_RTS, S_BITS, S_ACK, S_WAIT_REL};
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
    case (state_d)
      S_INHIBIT: begin
        // start bit goes out on the last inhibit cycle
        data_dir_d = (cnt_d == INH_LAST);
        data_out_d = (cnt_d != INH_LAST);
      end
      S_RTS, S_BITS: ;
      default: begin
        data_dir_d = 1'b0;
        data_out_d = 1'b1;
      end
    endcase
  end

  assign tx_busy      = busy_q;
  assign tx_done      = done_q;
  assign tx_err       = err_q;
  assign ps2_clk_out  = 1'b0;
  assign ps2_clk_dir  = clk_dir_q;
  assign ps2_data_out = data_out_q;
  assign ps2_data_dir = data_dir_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int INH  = 2500;
  localparam int TO   = 400;
  localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_err;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_out, ps2_clk_dir, ps2_data_out, ps2_data_dir;
  logic [3:0] state_out;
  logic       dev_clk  = 1'b1;
  logic       dev_data = 1'b1;

  // open-drain wired-AND of host and device with pull-ups
  assign ps2_clk_in  = (ps2_clk_dir  ? ps2_clk_out  : 1'b1) & dev_clk;
  assign ps2_data_in = (ps2_data_dir ? ps2_data_out : 1'b1) & dev_data;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_out(ps2_clk_out), .ps2_clk_dir(ps2_clk_dir),
    .ps2_data_out(ps2_data_out), .ps2_data_dir(ps2_data_dir),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int done_cnt = 0, err_cnt = 0;
  logic err_cdir = 1'b1, err_ddir = 1'b1;

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_err) begin
      err_cnt++;
      err_cdir = ps2_clk_dir;
      err_ddir = ps2_data_dir;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_tx(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
  endtask

  // Device model: waits out inhibit, then clocks n_falls falls, reading the
  // host data bit during each low phase; acks on fall #11 when ack=1.
  task automatic dev_frame(input bit ack, input int n_falls, input bit chk_inh,
                           output logic [9:0] bits, output bit ok);
    int   k, hi;
    logic last_dd, prev_dd;
    ok = 1'b1;
    bits = '0;
    k = 0;
    while (!ps2_clk_dir && k < 100) begin tick(1); k++; end
    if (!ps2_clk_dir) begin ok = 1'b0; return; end
    hi = 0; last_dd = 1'b0; prev_dd = 1'b0;
    while (ps2_clk_dir && hi < INH + 100) begin
      prev_dd = last_dd;
      last_dd = ps2_data_dir;
      tick(1);
      hi++;
    end
    if (chk_inh) begin
      check("inhibit_len", hi, INH);
      check("data_dir_last_inhibit", last_dd, 1'b1);
      check("data_dir_before_last", prev_dd, 1'b0);
      check("rts_data_low", ps2_data_in, 1'b0);
    end
    for (int i = 1; i <= n_falls; i++) begin
      tick(HALF / 2);
      if (i == 11 && ack) dev_data = 1'b0;
      tick(HALF / 2);
      dev_clk = 1'b0;
      tick(HALF);
      if (i <= 10) bits[i-1] = ps2_data_in;
      dev_clk = 1'b1;
    end
    tick(2);
    dev_data = 1'b1;
  endtask

  task automatic wait_end(input int limit, output int what);
    int cyc;
    cyc = 0;
    while (!tx_done && !tx_err && cyc < limit) begin tick(1); cyc++; end
    what = tx_done ? 1 : (tx_err ? 2 : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] bits;
    bit         ok;
    int         what, d0, e0, k;

    reset = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
    tick(3);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_err", tx_err, 1'b0);
    check("rst_clk_dir", ps2_clk_dir, 1'b0);
    check("rst_data_dir", ps2_data_dir, 1'b0);
    check("rst_data_out", ps2_data_out, 1'b1);
    check("rst_clk_out", ps2_clk_out, 1'b0);
    check("rst_state", state_out, 4'd0);
    reset = 1'b0;
    tick(2);

    // device->host clocking while idle must not wake the transmitter
    repeat (3) begin dev_clk = 1'b0; tick(HALF); dev_clk = 1'b1; tick(HALF); end
    check("idle_fall_state", state_out, 4'd0);
    check("idle_fall_clk_dir", ps2_clk_dir, 1'b0);
    check("idle_fall_data_dir", ps2_data_dir, 1'b0);

    // 0xF4: data 0,0,1,0,1,1,1,1, parity 0, stop 1
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hF4);
    check("f4_busy", tx_busy, 1'b1);
    dev_frame(1'b1, 11, 1'b1, bits, ok);
    check("f4_inhibit_seen", ok, 1'b1);
    check("f4_frame", bits, 10'h2F4);
    wait_end(200, what);
    check("f4_end", what, 1);
    // request in the done cycle is dropped
    tx_data = 8'h55; tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    check("start_on_done_state", state_out, 4'd0);
    check("start_on_done_busy", tx_busy, 1'b0);
    tick(5);
    check("f4_done_pulses", done_cnt - d0, 1);
    check("f4_err_pulses", err_cnt - e0, 0);
    check("f4_busy_after", tx_busy, 1'b0);
    check("start_on_done_idle", state_out, 4'd0);

    // 0xFF with a second request while busy: frame must stay 0xFF, parity 1
    start_tx(8'hFF);
    tick(3);
    tx_data = 8'h00; tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    dev_frame(1'b1, 11, 1'b0, bits, ok);
    check("ff_frame", bits, 10'h3FF);
    wait_end(200, what);
    check("ff_end", what, 1);
    tick(3);

    // 0x00: parity 1
    start_tx(8'h00);
    dev_frame(1'b1, 11, 1'b0, bits, ok);
    check("00_frame", bits, 10'h300);
    wait_end(200, what);
    check("00_end", what, 1);
    tick(3);

    // missing ack
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hF4);
    for (int a = 0; a < ATTEMPTS; a++) begin
      dev_frame(1'b0, 11, 1'b0, bits, ok);
      if (a < ATTEMPTS - 1) begin
        tick(5);
        check("nack_retry_no_err", err_cnt - e0, 0);
        check("nack_retry_busy", tx_busy, 1'b1);
      end
    end
    tick(20);
    check("nack_err_pulses", err_cnt - e0, 1);
    check("nack_done_pulses", done_cnt - d0, 0);
    check("nack_clk_dir_at_err", err_cdir, 1'b0);
    check("nack_data_dir_at_err", err_ddir, 1'b0);
    check("nack_busy", tx_busy, 1'b0);

    // device stops after fall #4: sync (3 edges) + TO+1 counting cycles
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hF4);
    dev_frame(1'b1, 3, 1'b0, bits, ok);
    tick(HALF);
    dev_clk = 1'b0;
    k = 0;
`ifdef PS2_TX_RETRY_EN
    while (!ps2_clk_dir && k < TO + 50) begin
`else
    while (!tx_err && k < TO + 50) begin
`endif
      @(posedge clk);
      k++;
      if (k == HALF) dev_clk = 1'b1;
      #1;
    end
    check("timeout_latency", k, TO + 4);
`ifdef PS2_TX_RETRY_EN
    check("timeout_retry_busy", tx_busy, 1'b1);
    reset = 1'b1; tick(1); reset = 1'b0;
`else
    tick(2);
    check("timeout_err_pulses", err_cnt - e0, 1);
    check("timeout_clk_dir", ps2_clk_dir, 1'b0);
    check("timeout_data_dir", ps2_data_dir, 1'b0);
    check("timeout_busy", tx_busy, 1'b0);
`endif
    tick(5);

    // reset after fall #5
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hF4);
    dev_frame(1'b1, 5, 1'b0, bits, ok);
    tick(3);
    check("pre_reset_busy", tx_busy, 1'b1);
    reset = 1'b1;
    tick(1);
    check("midrst_state", state_out, 4'd0);
    check("midrst_clk_dir", ps2_clk_dir, 1'b0);
    check("midrst_data_dir", ps2_data_dir, 1'b0);
    check("midrst_busy", tx_busy, 1'b0);
    reset = 1'b0;
    tick(50);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_err", err_cnt - e0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
